// File: rtl/spi_xfer_arbiter.sv
// Round-robin sequencer that runs complete SPI register-bus transactions for two requesters.
// Optional macro SPI_ARB_FIXED_PRIO_EN: requester 0 wins every contention (no last_grant state).
module spi_xfer_arbiter #(
  parameter int XFER_CYCLES = 150,
  parameter int CNT_W       = $clog2(XFER_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_rd,
  input  logic [7:0]  req0_cmd,
  input  logic [23:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_rd,
  input  logic [7:0]  req1_cmd,
  input  logic [23:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic [2:0]  spi_addr,
  output logic        spi_we,
  output logic [31:0] spi_wdata,
  output logic        spi_re,
  input  logic [31:0] spi_rdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_ADDR,
    S_WR_DATA,
    S_START,
    S_CLR,
    S_WAIT,
    S_RD_REQ,
    S_RD_CAP,
    S_DONE
  } state_t;

  state_t            state;
  logic              lat_id;
  logic              lat_rd;
  logic [7:0]        lat_cmd;
  logic [23:0]       lat_addr;
  logic [31:0]       lat_data;
  logic [CNT_W-1:0]  cnt;
  logic              grant_id;

`ifndef SPI_ARB_FIXED_PRIO_EN
  logic              last_grant;
`endif

  always_comb begin
    grant_id = req0_valid ? 1'b0 : 1'b1;
`ifdef SPI_ARB_FIXED_PRIO_EN
    grant_id = req0_valid ? 1'b0 : 1'b1;
`else
    // On contention the requester that was not served last time wins.
    if (req0_valid && req1_valid)
      grant_id = ~last_grant;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      lat_id     <= 1'b0;
      lat_rd     <= 1'b0;
      lat_cmd    <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      cnt        <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            lat_id   <= grant_id;
            lat_rd   <= grant_id ? req1_rd    : req0_rd;
            lat_cmd  <= grant_id ? req1_cmd   : req0_cmd;
            lat_addr <= grant_id ? req1_addr  : req0_addr;
            lat_data <= grant_id ? req1_wdata : req0_wdata;
            state    <= S_WR_CMD;
          end
        end
        S_WR_CMD:  state <= S_WR_ADDR;
        S_WR_ADDR: state <= S_WR_DATA;
        S_WR_DATA: state <= S_START;
        S_START:   state <= S_CLR;
        S_CLR: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CNT_W'(XFER_CYCLES - 1)) begin
            if (lat_rd) begin
              state <= S_RD_REQ;
            end else begin
              state <= S_DONE;
              if (lat_id) req1_done <= 1'b1;
              else        req0_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          // spi_rdata answers the read enable issued one cycle earlier.
          if (lat_id) begin
            req1_rdata <= spi_rdata;
            req1_done  <= 1'b1;
          end else begin
            req0_rdata <= spi_rdata;
            req0_done  <= 1'b1;
          end
          state <= S_DONE;
        end
        S_DONE: begin
`ifndef SPI_ARB_FIXED_PRIO_EN
          last_grant <= lat_id;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    spi_addr  = 3'd0;
    spi_we    = 1'b0;
    spi_wdata = 32'h0;
    spi_re    = 1'b0;
    case (state)
      S_WR_CMD: begin
        spi_addr  = 3'd1;
        spi_we    = 1'b1;
        spi_wdata = {24'h0, lat_cmd};
      end
      S_WR_ADDR: begin
        spi_addr  = 3'd2;
        spi_we    = 1'b1;
        spi_wdata = {8'h0, lat_addr};
      end
      S_WR_DATA: begin
        spi_addr  = 3'd3;
        spi_we    = 1'b1;
        spi_wdata = lat_data;
      end
      S_START: begin
        spi_we    = 1'b1;
        spi_wdata = 32'h1;
      end
      S_CLR: begin
        spi_we    = 1'b1;
      end
      S_RD_REQ: begin
        spi_addr  = 3'd4;
        spi_re    = 1'b1;
      end
      default: begin
        spi_addr  = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: directed scenarios then random traffic, every cycle checked
// against a transaction-level model built from offsets relative to the grant cycle.
module tb_spi_xfer_arbiter;

  localparam int X       = 8;
  localparam int DONE_WR = 6 + X;
  localparam int DONE_RD = 8 + X;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v[2];
  logic        rdf[2];
  logic [7:0]  cmd[2];
  logic [23:0] addr[2];
  logic [31:0] wdata[2];
  logic [31:0] spi_rdata = '0;

  logic        req0_done, req1_done;
  logic [31:0] req0_rdata, req1_rdata;
  logic [2:0]  spi_addr;
  logic        spi_we, spi_re;
  logic [31:0] spi_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          m_busy;
  int          m_off;
  int          m_id;
  bit          m_rd;
  logic [7:0]  m_cmd;
  logic [23:0] m_addr;
  logic [31:0] m_data;
  int          m_last;
  logic [31:0] m_rdata[2];
  int          m_grant_cyc;

  int done_cnt[2];
  int done_cyc[2];
  int re_cyc;
  int wrcmd_cyc;
  int order[$];
  int reraise[2];

  spi_xfer_arbiter #(.XFER_CYCLES(X)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_rd    (rdf[0]),
    .req0_cmd   (cmd[0]),
    .req0_addr  (addr[0]),
    .req0_wdata (wdata[0]),
    .req0_done  (req0_done),
    .req0_rdata (req0_rdata),
    .req1_valid (v[1]),
    .req1_rd    (rdf[1]),
    .req1_cmd   (cmd[1]),
    .req1_addr  (addr[1]),
    .req1_wdata (wdata[1]),
    .req1_done  (req1_done),
    .req1_rdata (req1_rdata),
    .spi_addr   (spi_addr),
    .spi_we     (spi_we),
    .spi_wdata  (spi_wdata),
    .spi_re     (spi_re),
    .spi_rdata  (spi_rdata)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int id, input logic valid, input logic rd,
                               input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
    v[id]     = valid;
    rdf[id]   = rd;
    cmd[id]   = c;
    addr[id]  = a;
    wdata[id] = d;
  endtask

  function automatic logic doneOf(input int id);
    return (id == 0) ? req0_done : req1_done;
  endfunction

  // Reference model: advances one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    if (!rst) begin
      m_busy     = 1'b0;
      m_last     = 1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
    end else if (!m_busy) begin
      if (v[0] || v[1]) begin
        if (v[0] && v[1]) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
          m_id = 0;
`else
          m_id = 1 - m_last;
`endif
        end else begin
          m_id = v[0] ? 0 : 1;
        end
        m_rd        = rdf[m_id];
        m_cmd       = cmd[m_id];
        m_addr      = addr[m_id];
        m_data      = wdata[m_id];
        m_busy      = 1'b1;
        m_off       = 1;
        m_grant_cyc = cyc - 1;
      end
    end else begin
      if (m_rd && m_off == 7 + X)
        m_rdata[m_id] = spi_rdata;
      if (m_off == (m_rd ? DONE_RD : DONE_WR)) begin
        m_busy = 1'b0;
        m_last = m_id;
      end else begin
        m_off++;
      end
    end
  endtask

  task automatic tick();
    logic [2:0]  e_addr;
    logic        e_we, e_re, e_done0, e_done1;
    logic [31:0] e_wdata;
    @(posedge clk);
    cyc++;
    modelEdge();
    e_addr = 3'd0; e_we = 1'b0; e_re = 1'b0; e_wdata = '0; e_done0 = 1'b0; e_done1 = 1'b0;
    if (m_busy) begin
      case (m_off)
        1: begin e_addr = 3'd1; e_we = 1'b1; e_wdata = {24'h0, m_cmd}; end
        2: begin e_addr = 3'd2; e_we = 1'b1; e_wdata = {8'h0, m_addr}; end
        3: begin e_addr = 3'd3; e_we = 1'b1; e_wdata = m_data; end
        4: begin e_addr = 3'd0; e_we = 1'b1; e_wdata = 32'h1; end
        5: begin e_addr = 3'd0; e_we = 1'b1; e_wdata = 32'h0; end
        default: ;
      endcase
      if (m_rd && m_off == 6 + X) begin e_addr = 3'd4; e_re = 1'b1; end
      if (m_off == (m_rd ? DONE_RD : DONE_WR)) begin
        if (m_id == 0) e_done0 = 1'b1;
        else           e_done1 = 1'b1;
      end
    end
    #1;
    checkOutput("spi_addr",   32'(spi_addr),  32'(e_addr));
    checkOutput("spi_we",     32'(spi_we),    32'(e_we));
    checkOutput("spi_wdata",  spi_wdata,      e_wdata);
    checkOutput("spi_re",     32'(spi_re),    32'(e_re));
    checkOutput("req0_done",  32'(req0_done), 32'(e_done0));
    checkOutput("req1_done",  32'(req1_done), 32'(e_done1));
    checkOutput("req0_rdata", req0_rdata,     m_rdata[0]);
    checkOutput("req1_rdata", req1_rdata,     m_rdata[1]);
    if (req0_done === 1'b1) begin done_cnt[0]++; done_cyc[0] = cyc; order.push_back(0); end
    if (req1_done === 1'b1) begin done_cnt[1]++; done_cyc[1] = cyc; order.push_back(1); end
    if (spi_re === 1'b1) re_cyc = cyc;
    if (spi_we === 1'b1 && spi_addr === 3'd1) wrcmd_cyc = cyc;
  endtask

  task automatic waitDone(input int id, input int budget);
    int start;
    int n;
    start = done_cnt[id];
    n = 0;
    while (done_cnt[id] == start && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_seen", 32'(done_cnt[id] - start), 32'd1);
    v[id] = 1'b0;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(i, 1'b0, 1'b0, 8'h0, 24'h0, 32'h0);
      m_rdata[i]  = '0;
      done_cnt[i] = 0;
      done_cyc[i] = 0;
      reraise[i]  = -1;
    end
    m_busy = 1'b0; m_last = 1; m_off = 0; m_id = 0; m_rd = 1'b0;
    m_cmd = '0; m_addr = '0; m_data = '0; m_grant_cyc = 0;
    re_cyc = 0; wrcmd_cyc = 0;

    $display("[TB] reset");
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    $display("[TB] single write");
    applyStimulus(0, 1'b1, 1'b0, 8'hA5, 24'h123456, 32'h789ABCDE);
    waitDone(0, 40);
    checkOutput("wr_latency", 32'(done_cyc[0] - m_grant_cyc), 32'd14);

    $display("[TB] single read");
    spi_rdata = 32'hDEADBEEF;
    applyStimulus(1, 1'b1, 1'b1, 8'h3C, 24'hABCDEF, 32'h01020304);
    waitDone(1, 40);
    checkOutput("rd_re_cycle", 32'(re_cyc - m_grant_cyc), 32'd14);
    checkOutput("rd_latency",  32'(done_cyc[1] - m_grant_cyc), 32'd16);
    checkOutput("rd_rdata1",   req1_rdata, 32'hDEADBEEF);
    checkOutput("rd_rdata0",   req0_rdata, 32'h0);

    $display("[TB] contention");
    applyStimulus(0, 1'b1, 1'b0, 8'($urandom), 24'($urandom), $urandom);
    applyStimulus(1, 1'b1, 1'b1, 8'($urandom), 24'($urandom), $urandom);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    order.delete();
    reraise[0] = -1;
    reraise[1] = -1;
    for (int n = 0; n < 300 && order.size() < 4; n++) begin
      spi_rdata = $urandom;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (doneOf(i) === 1'b1) begin
          v[i] = 1'b0;
          reraise[i] = cyc + 2;
        end else if (!v[i] && cyc == reraise[i]) begin
          applyStimulus(i, 1'b1, (i == 1), 8'($urandom), 24'($urandom), $urandom);
        end
      end
    end
    checkOutput("grant_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput("grant_order", (order.size() > k) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(k % 2));

    $display("[TB] reset during wait");
    v[0] = 1'b0;
    v[1] = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 8'h11, 24'h222222, 32'h33333333);
    for (int n = 0; n < 30 && !(m_busy && m_off == 9); n++)
      tick();
    v[0] = 1'b0;
    base = done_cnt[0] + done_cnt[1];
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("rst_spi_we",   32'(spi_we),   32'd0);
    checkOutput("rst_spi_addr", 32'(spi_addr), 32'd0);
    checkOutput("rst_rdata0",   req0_rdata,    32'h0);
    checkOutput("rst_rdata1",   req1_rdata,    32'h0);
    repeat (25) tick();
    checkOutput("rst_no_done", 32'(done_cnt[0] + done_cnt[1] - base), 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 8'h44, 24'h555555, 32'h66666666);
    waitDone(1, 40);

    $display("[TB] back-to-back");
    applyStimulus(0, 1'b1, 1'b0, 8'h77, 24'h888888, 32'h99999999);
    waitDone(0, 40);
    base = done_cyc[0];
    tick();
    applyStimulus(0, 1'b1, 1'b0, 8'hAA, 24'hBBBBBB, 32'hCCCCCCCC);
    tick();
    checkOutput("b2b_gap", 32'(wrcmd_cyc - base), 32'd2);
    waitDone(0, 40);

    $display("[TB] valid dropped mid-transaction");
    base = done_cnt[0];
    applyStimulus(0, 1'b1, 1'b1, 8'h5A, 24'h0F0F0F, 32'hF0F0F0F0);
    spi_rdata = 32'h13572468;
    for (int n = 0; n < 20 && !(spi_we === 1'b1 && spi_addr === 3'd2); n++)
      tick();
    v[0] = 1'b0;
    repeat (30) tick();
    checkOutput("drop_done_count", 32'(done_cnt[0] - base), 32'd1);
    checkOutput("drop_rdata0", req0_rdata, 32'h13572468);

    $display("[TB] random traffic");
    for (int c = 0; c < 700; c++) begin
      rst = ($urandom_range(0, 149) != 0);
      spi_rdata = $urandom;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (doneOf(i) === 1'b1)
          v[i] = 1'b0;
        else if (!v[i] && $urandom_range(0, 2) == 0)
          applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 24'($urandom), $urandom);
      end
    end
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
